// File: rtl/jk_defs.sv
// rtl/jk_defs.sv - shared FSM encodings and JK excitation function (JK_TOGGLE_EXCITE_EN selects toggle excitation)
package jk_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_VERIFY = 2'd2
  } jk_state_t;

  // Returns {j, k} for one flop moving from q to t.
  function automatic logic [1:0] excite(input logic q, input logic t);
`ifdef JK_TOGGLE_EXCITE_EN
    excite = {q ^ t, q ^ t};
`else
    excite = {~q & t, q & ~t};
`endif
  endfunction

endpackage

// File: rtl/jk_tx_fifo.sv
// rtl/jk_tx_fifo.sv - synchronous target FIFO with async active-low clear
module jk_tx_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign level     = r_wr_ptr - r_rd_ptr;
  assign full      = (level == (AW+1)'(DEPTH));
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign dout      = r_mem[r_rd_ptr[AW-1:0]];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/jk_excite_tx.sv
// rtl/jk_excite_tx.sv - JK bank stimulus driver: target FIFO, excitation FSM, verify checker (JK_TOGGLE_EXCITE_EN selects toggle excitation)
module jk_excite_tx
  import jk_defs::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     enable,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [WIDTH-1:0]         q_fb,
  output logic [WIDTH-1:0]         j,
  output logic [WIDTH-1:0]         k,
  output logic                     jk_valid,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err,
  output logic [CNT_W-1:0]         err_count
);

  jk_state_t        r_state;
  jk_state_t        w_state_nxt;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic             r_err;
  logic [CNT_W-1:0] r_err_count;

  logic [WIDTH-1:0] w_head;
  logic [WIDTH-1:0] w_exc_j;
  logic [WIDTH-1:0] w_exc_k;
  logic [WIDTH-1:0] w_j_nxt;
  logic [WIDTH-1:0] w_k_nxt;
  logic             w_full;
  logic             w_empty;
  logic             w_load;
  logic             w_check;
  logic             w_mismatch;

  // The FIFO ignores push while full, so in_valid can feed it directly.
  jk_tx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (in_valid),
    .pop   (w_load),
    .din   (in_data),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (level)
  );

  // Per-bit excitation from the current bank state toward the FIFO head.
  always_comb begin
    w_exc_j = '0;
    w_exc_k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {w_exc_j[i], w_exc_k[i]} = excite(q_fb[i], w_head[i]);
    end
  end

  // Next-state and excitation register inputs; enable low freezes everything.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_check     = 1'b0;
    w_j_nxt     = r_j;
    w_k_nxt     = r_k;
    case (r_state)
      ST_IDLE: begin
        w_j_nxt = '0;
        w_k_nxt = '0;
        if (enable && !w_empty) begin
          w_load      = 1'b1;
          w_state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (enable) begin
          w_j_nxt     = '0;
          w_k_nxt     = '0;
          w_state_nxt = ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        w_j_nxt = '0;
        w_k_nxt = '0;
        if (enable) begin
          w_check = 1'b1;
          if (!w_empty) begin
            w_load      = 1'b1;
            w_state_nxt = ST_DRIVE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_j_nxt     = '0;
        w_k_nxt     = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (w_load) begin
      w_j_nxt = w_exc_j;
      w_k_nxt = w_exc_k;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Excitation and target registers; the target is captured on every load.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_j      <= '0;
      r_k      <= '0;
      r_target <= '0;
    end else begin
      r_j <= w_j_nxt;
      r_k <= w_k_nxt;
      if (w_load) r_target <= w_head;
    end
  end

  assign w_mismatch = w_check && (q_fb != r_target);

  // Sticky error flag and saturating mismatch counter.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else if (w_mismatch) begin
      r_err <= 1'b1;
      if (r_err_count != '1) r_err_count <= r_err_count + CNT_W'(1);
    end
  end

  assign in_ready  = ~w_full;
  assign j         = enable ? r_j : '0;
  assign k         = enable ? r_k : '0;
  assign jk_valid  = enable && (r_state == ST_DRIVE);
  assign busy      = (r_state != ST_IDLE) || !w_empty;
  assign err       = r_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_jk_excite_tx.sv
// tb/tb_jk_excite_tx.sv - directed self-checking bench for jk_excite_tx (JK_TOGGLE_EXCITE_EN aware)
module tb_jk_excite_tx;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       enable = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = 4'h0;
  logic [3:0] q_fb;
  logic [3:0] j;
  logic [3:0] k;
  logic       jk_valid;
  logic       busy;
  logic [2:0] level;
  logic       err;
  logic [7:0] err_count;

  int tests = 0;
  int fails = 0;

  // JK bank model: loadable, or frozen to ignore the drive.
  logic [3:0] q_m = 4'h0;
  logic [3:0] m_val = 4'h0;
  logic       m_load = 1'b0;
  logic       m_freeze = 1'b0;

  assign q_fb = q_m;

  always #5 clk = ~clk;

  // Behavioural JK flop bank.
  always @(posedge clk) begin
    if (m_load) q_m <= m_val;
    else if (!m_freeze) q_m <= (j & ~q_m) | (~k & q_m);
  end

  jk_excite_tx dut (
    .clk       (clk),
    .clr       (clr),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .q_fb      (q_fb),
    .j         (j),
    .k         (k),
    .jk_valid  (jk_valid),
    .busy      (busy),
    .level     (level),
    .err       (err),
    .err_count (err_count)
  );

  function automatic logic [3:0] exp_j(input logic [3:0] q, input logic [3:0] t);
`ifdef JK_TOGGLE_EXCITE_EN
    return q ^ t;
`else
    return ~q & t;
`endif
  endfunction

  function automatic logic [3:0] exp_k(input logic [3:0] q, input logic [3:0] t);
`ifdef JK_TOGGLE_EXCITE_EN
    return q ^ t;
`else
    return q & ~t;
`endif
  endfunction

  task automatic do_reset();
    enable = 1'b0; in_valid = 1'b0; m_freeze = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic set_q(input logic [3:0] v);
    m_val = v; m_load = 1'b1;
    @(negedge clk);
    m_load = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    clr = 1'b0; in_valid = 1'b1; in_data = 4'h9; enable = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests++; if (level !== 3'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", level); end
    tests++; if (j !== 4'h0 || k !== 4'h0) begin fails++; $display("FAIL reset_jk: got j=%b k=%b want 0000", j, k); end
    tests++; if (err !== 1'b0 || err_count !== 8'd0) begin fails++; $display("FAIL reset_err: got err=%b cnt=%0d want 0", err, err_count); end
    tests++; if (busy !== 1'b0 || jk_valid !== 1'b0) begin fails++; $display("FAIL reset_busy: got busy=%b jk_valid=%b want 0", busy, jk_valid); end
    clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    tests++; if (level !== 3'd1) begin fails++; $display("FAIL reset_first_push: level got %0d want 1", level); end
  endtask

  task automatic test_single();
    do_reset();
    set_q(4'b0011);
    enable = 1'b1; in_valid = 1'b1; in_data = 4'b0101;
    @(negedge clk);
    in_valid = 1'b0;
    tests++; if (jk_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL single_after_push: jk_valid=%b busy=%b want 0/1", jk_valid, busy); end
    @(negedge clk);
    tests++; if (jk_valid !== 1'b1) begin fails++; $display("FAIL single_jk_valid: got %b want 1", jk_valid); end
    tests++; if (j !== exp_j(4'b0011, 4'b0101)) begin fails++; $display("FAIL single_j: got %b want %b", j, exp_j(4'b0011, 4'b0101)); end
    tests++; if (k !== exp_k(4'b0011, 4'b0101)) begin fails++; $display("FAIL single_k: got %b want %b", k, exp_k(4'b0011, 4'b0101)); end
    @(negedge clk);
    tests++; if (jk_valid !== 1'b0 || j !== 4'h0 || k !== 4'h0) begin fails++; $display("FAIL single_verify_jk: jk_valid=%b j=%b k=%b want 0", jk_valid, j, k); end
    tests++; if (q_m !== 4'b0101) begin fails++; $display("FAIL single_bank_q: got %b want 0101", q_m); end
    @(negedge clk);
    tests++; if (err !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL single_done: err=%b busy=%b want 0/0", err, busy); end
  endtask

  task automatic test_backpressure();
    logic [3:0] w [5];
    int idx;
    int last;
    bit pushed;
    w[0] = 4'b1010; w[1] = 4'b0110; w[2] = 4'b1111; w[3] = 4'b0000; w[4] = 4'b1001;
    do_reset();
    set_q(4'b0000);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = w[i];
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_%0d: got %b want 1", i, in_ready); end
      @(negedge clk);
    end
    in_data = w[4];
    tests++; if (in_ready !== 1'b0 || level !== 3'd4) begin fails++; $display("FAIL bp_full: in_ready=%b level=%0d want 0/4", in_ready, level); end
    @(negedge clk);
    tests++; if (level !== 3'd4 || jk_valid !== 1'b0) begin fails++; $display("FAIL bp_hold: level=%0d jk_valid=%b want 4/0", level, jk_valid); end
    enable = 1'b1;
    idx = 0; last = -1; pushed = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (jk_valid) begin
        if (idx < 5) begin
          tests++; if (j !== exp_j(q_m, w[idx]) || k !== exp_k(q_m, w[idx])) begin
            fails++; $display("FAIL bp_drain_%0d: j=%b k=%b want j=%b k=%b", idx, j, k, exp_j(q_m, w[idx]), exp_k(q_m, w[idx]));
          end
        end
        if (idx > 0) begin
          tests++; if (c - last != 2) begin fails++; $display("FAIL bp_spacing_%0d: got %0d cycles want 2", idx, c - last); end
        end
        last = c; idx++;
      end
      if (in_valid && in_ready) pushed = 1'b1;
      @(negedge clk);
      if (pushed) in_valid = 1'b0;
      if (idx >= 5 && !busy) break;
    end
    tests++; if (idx != 5) begin fails++; $display("FAIL bp_count: got %0d drives want 5", idx); end
    tests++; if (q_m !== w[4] || err !== 1'b0) begin fails++; $display("FAIL bp_final: q=%b err=%b want %b/0", q_m, err, w[4]); end
  endtask

  task automatic test_mismatch();
    bit ok;
    int pushes;
    int c;
    do_reset();
    set_q(4'b0000);
    m_freeze = 1'b1; enable = 1'b1;
    in_valid = 1'b1; in_data = 4'b1111;
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle(20, ok);
    tests++; if (!ok) begin fails++; $display("FAIL mm_timeout1: busy stuck at %b want 0", busy); end
    tests++; if (err !== 1'b1 || err_count !== 8'd1) begin fails++; $display("FAIL mm_first: err=%b cnt=%0d want 1/1", err, err_count); end
    m_freeze = 1'b0;
    in_valid = 1'b1; in_data = 4'b0000;
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle(20, ok);
    tests++; if (!ok || err !== 1'b1 || err_count !== 8'd1) begin fails++; $display("FAIL mm_sticky: ok=%b err=%b cnt=%0d want 1/1/1", ok, err, err_count); end
    m_freeze = 1'b1;
    in_valid = 1'b1; in_data = 4'b1111;
    pushes = 0; c = 0;
    while (pushes < 299 && c < 2000) begin
      if (in_ready) pushes++;
      @(negedge clk);
      c++;
    end
    in_valid = 1'b0;
    wait_idle(100, ok);
    tests++; if (!ok || pushes != 299) begin fails++; $display("FAIL mm_stream: ok=%b pushes=%0d want 1/299", ok, pushes); end
    tests++; if (err_count !== 8'd255 || err !== 1'b1) begin fails++; $display("FAIL mm_saturate: cnt=%0d err=%b want 255/1", err_count, err); end
    m_freeze = 1'b0;
  endtask

  task automatic test_enable_gap();
    bit ok;
    logic [3:0] ej;
    logic [3:0] ek;
    ej = exp_j(4'b0011, 4'b0101);
    ek = exp_k(4'b0011, 4'b0101);
    do_reset();
    set_q(4'b0011);
    enable = 1'b1; in_valid = 1'b1; in_data = 4'b0101;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    tests++; if (jk_valid !== 1'b1 || j !== ej) begin fails++; $display("FAIL gap_drive: jk_valid=%b j=%b want 1/%b", jk_valid, j, ej); end
    enable = 1'b0; in_valid = 1'b1; in_data = 4'b1000;
    #1;
    tests++; if (j !== 4'h0 || k !== 4'h0 || jk_valid !== 1'b0) begin fails++; $display("FAIL gap_gated: j=%b k=%b jk_valid=%b want 0", j, k, jk_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      tests++; if (j !== 4'h0 || jk_valid !== 1'b0 || q_m !== 4'b0011) begin fails++; $display("FAIL gap_hold_%0d: j=%b jk_valid=%b q=%b want 0/0/0011", i, j, jk_valid, q_m); end
    end
    tests++; if (level !== 3'd1) begin fails++; $display("FAIL gap_push: level=%0d want 1", level); end
    enable = 1'b1;
    #1;
    tests++; if (jk_valid !== 1'b1 || j !== ej || k !== ek) begin fails++; $display("FAIL gap_resume: jk_valid=%b j=%b k=%b want 1/%b/%b", jk_valid, j, k, ej, ek); end
    wait_idle(20, ok);
    tests++; if (!ok || err !== 1'b0 || q_m !== 4'b1000) begin fails++; $display("FAIL gap_final: ok=%b err=%b q=%b want 1/0/1000", ok, err, q_m); end
  endtask

  task automatic test_clr_verify();
    do_reset();
    set_q(4'b0011);
    enable = 1'b1; in_valid = 1'b1; in_data = 4'b0101;
    @(negedge clk);
    in_data = 4'b1100;
    @(negedge clk);
    in_valid = 1'b0;
    tests++; if (j !== exp_j(4'b0011, 4'b0101) || k !== exp_k(4'b0011, 4'b0101)) begin
      fails++; $display("FAIL clr_drive_jk: j=%b k=%b want %b/%b", j, k, exp_j(4'b0011, 4'b0101), exp_k(4'b0011, 4'b0101));
    end
    @(negedge clk);
    tests++; if (jk_valid !== 1'b0 || level !== 3'd1) begin fails++; $display("FAIL clr_in_verify: jk_valid=%b level=%0d want 0/1", jk_valid, level); end
    #2 clr = 1'b0;
    #1;
    tests++; if (level !== 3'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL clr_async_fifo: level=%0d in_ready=%b busy=%b want 0/1/0", level, in_ready, busy); end
    tests++; if (j !== 4'h0 || k !== 4'h0 || err !== 1'b0 || err_count !== 8'd0) begin fails++; $display("FAIL clr_async_out: j=%b k=%b err=%b cnt=%0d want 0", j, k, err, err_count); end
    @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (busy !== 1'b0 || jk_valid !== 1'b0) begin fails++; $display("FAIL clr_discard: busy=%b jk_valid=%b want 0/0", busy, jk_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_mismatch();
    test_enable_gap();
    test_clr_verify();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
